ps2_rx_fifo: RTL

Parametrised PS/2 device-to-host receiver with a configurable glitch filter, full frame checking (start, odd parity, stop), an inter-bit timeout watchdog and a first-word-fall-through scan-code FIFO. It sits between the keyboard pins and the scan-code-to-ASCII translation logic. It replaces the single-byte, unchecked receiver so that bursts of scan codes such as break sequences and extended codes are buffered and corrupted frames are flagged.

---
 rtl/ps2_rx_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: glitch filter, start/odd-parity/stop check, inter-bit watchdog, FWFT scan-code FIFO.
// Latency: entry visible 2 cycles after the stop-bit falling edge; ticks are combinational state decodes.
// Backpressure: none toward the device; a frame completing into a full FIFO (no same-cycle pop) is dropped with overflow_tick.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8,
    parameter bit DROP_ERRORED   = 1'b0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ps2d,
    input  logic                              ps2c,
    input  logic                              rx_en,
    input  logic                              rd_en,
    output logic [7:0]                        dout,
    output logic                              dout_err,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              busy,
    output logic                              parity_err_tick,
    output logic                              frame_err_tick,
    output logic                              timeout_tick,
    output logic                              overflow_tick
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

    logic [1:0]            c_sync, d_sync;
    logic [FILTER_LEN-1:0] filt_reg;
    logic                  fc_reg, fc_next, fall, ps2d_s;

    state_t        state, state_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [9:0]    sreg, sreg_next;
    logic [TW-1:0] timer, timer_next;
    logic          perr, ferr, push_req, push, pop;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign ps2d_s = d_sync[1];

    // Lines idle high, so sync and filter reset to ones to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync   <= 2'b11;
            d_sync   <= 2'b11;
            filt_reg <= '1;
            fc_reg   <= 1'b1;
        end else begin
            c_sync   <= {c_sync[0], ps2c};
            d_sync   <= {d_sync[0], ps2d};
            filt_reg <= {c_sync[1], filt_reg[FILTER_LEN-1:1]};
            fc_reg   <= fc_next;
        end
    end

    always_comb begin
        fc_next = fc_reg;
        if (&filt_reg)
            fc_next = 1'b1;
        else if (~|filt_reg)
            fc_next = 1'b0;
    end

    assign fall = fc_reg & ~fc_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sreg    <= '0;
            timer   <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            sreg    <= sreg_next;
            timer   <= timer_next;
        end
    end

    assign perr = ~(^sreg[7:0] ^ sreg[8]);
    assign ferr = ~sreg[9];

    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        sreg_next       = sreg;
        timer_next      = timer;
        push_req        = 1'b0;
        parity_err_tick = 1'b0;
        frame_err_tick  = 1'b0;
        timeout_tick    = 1'b0;
        case (state)
            IDLE: begin
                if (fall && rx_en) begin
                    if (!ps2d_s) begin
                        bit_cnt_next = '0;
                        timer_next   = '0;
                        state_next   = DATA;
                    end else begin
                        frame_err_tick = 1'b1;
                    end
                end
            end
            DATA: begin
                // sreg fills from the top: data LSB ends in bit 0, stop in bit 9.
                if (fall) begin
                    sreg_next    = {ps2d_s, sreg[9:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    timer_next   = '0;
                    if (bit_cnt == 4'd9)
                        state_next = CHECK;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_tick = 1'b1;
                    state_next   = IDLE;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            CHECK: begin
                parity_err_tick = perr;
                frame_err_tick  = ferr;
                push_req        = !(DROP_ERRORED && (perr || ferr));
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop           = rd_en & ~empty;
    assign push          = push_req & (~full | rd_en);
    assign overflow_tick = push_req & full & ~rd_en;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {perr | ferr, sreg[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign dout     = empty ? 8'h00 : mem[rd_ptr][7:0];
    assign dout_err = empty ? 1'b0 : mem[rd_ptr][8];
endmodule
